// File: rtl/loader_pkg.sv
// Shared encodings for the instruction-memory stream loader: FSM states,
// abort codes, the default frame header and a helper for the HI-byte check.
package loader_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_LO    = 3'd2;
  localparam logic [2:0] S_HI    = 3'd3;
  localparam logic [2:0] S_CSUM  = 3'd4;
  localparam logic [2:0] S_START = 3'd5;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_COUNT   = 3'd1;
  localparam logic [2:0] ERR_FORMAT  = 3'd2;
  localparam logic [2:0] ERR_CSUM    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Bits of the HI byte that fall outside the instruction word; any of them
  // set means the frame is malformed. A 16-bit word uses the whole byte.
  function automatic logic [7:0] hi_bad_mask(input int ir_width);
    logic [7:0] mask;
    mask = 8'h00;
    for (int b = 0; b < 8; b++) begin
      if (b >= ir_width - 8) mask[b] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/byte_timeout_counter.sv
// Counts idle cycles inside a frame. expired is high on the TIMEOUT-th
// consecutive enabled cycle without a clear; the owner decides whether an
// accepted byte on that same cycle overrides it.
module byte_timeout_counter #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  assign expired = en && (count == LAST);

  // Idle-cycle counter; saturates at LAST so it never wraps back to zero.
  // NOTE: registers use non-blocking assignment so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/imem_stream_loader.sv
// Boot loader: parses SYNC, N, {LO,HI} x N, CSUM from a valid/ready byte
// link, writes each word to instruction memory one cycle after its HI byte,
// and pulses start when the XOR checksum matches. Any abort returns to IDLE
// with a sticky error code.
module imem_stream_loader
  import loader_pkg::*;
#(
  parameter int                     IR_width      = 12,
  parameter int                     IM_addr_width = 8,
  parameter logic [IM_addr_width-1:0] BASE_ADDR   = '0,
  parameter logic [7:0]             SYNC_BYTE     = DEFAULT_SYNC_BYTE,
  parameter int                     TIMEOUT       = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     rx_ready,
  output logic                     imem_we,
  output logic [IM_addr_width-1:0] imem_addr,
  output logic [IR_width-1:0]      imem_wdata,
  output logic                     proc_hold,
  output logic                     start,
  output logic                     done,
  output logic                     err,
  output logic [2:0]               err_code
);

  localparam int unsigned MAX_WORDS = (1 << IM_addr_width) - int'(BASE_ADDR);
  localparam logic [7:0]  HI_BAD_MASK = hi_bad_mask(IR_width);

  logic [2:0] state;
  logic [7:0] n_words;
  logic [7:0] idx;
  logic [7:0] lo_byte;
  logic [7:0] csum;
  logic       accept;
  logic       active;
  logic       tmo_clr;
  logic       tmo_expired;
  logic       fail;
  logic [2:0] fail_code;
  logic [8:0] idx_inc;

  assign active    = (state == S_COUNT) || (state == S_LO) ||
                     (state == S_HI)    || (state == S_CSUM);
  assign rx_ready  = reset && (state != S_START);
  assign accept    = rx_valid && rx_ready;
  assign proc_hold = active;
  assign tmo_clr   = !reset || accept || !active;
  assign idx_inc   = {1'b0, idx} + 9'd1;

  byte_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .clr     (tmo_clr),
    .en      (active),
    .expired (tmo_expired)
  );

  // Abort detection; an accepted byte always wins over a timeout in the same cycle.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    fail      = 1'b0;
    fail_code = ERR_NONE;
    if (accept) begin
      case (state)
        S_COUNT: if (rx_data == 8'h00 || 32'(rx_data) > MAX_WORDS) begin
          fail      = 1'b1;
          fail_code = ERR_COUNT;
        end
        S_HI: if ((rx_data & HI_BAD_MASK) != 8'h00) begin
          fail      = 1'b1;
          fail_code = ERR_FORMAT;
        end
        S_CSUM: if (rx_data != csum) begin
          fail      = 1'b1;
          fail_code = ERR_CSUM;
        end
        default: ;
      endcase
    end else if (active && tmo_expired) begin
      fail      = 1'b1;
      fail_code = ERR_TIMEOUT;
    end
  end

  // Frame FSM with checksum, word index and registered memory-write port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      n_words    <= '0;
      idx        <= '0;
      lo_byte    <= '0;
      csum       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      start      <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      imem_we <= 1'b0;
      start   <= 1'b0;
      if (fail) begin
        state    <= S_IDLE;
        err      <= 1'b1;
        err_code <= fail_code;
      end else begin
        case (state)
          S_IDLE: if (accept && rx_data == SYNC_BYTE) begin
            state    <= S_COUNT;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
          end
          S_COUNT: if (accept) begin
            n_words <= rx_data;
            idx     <= '0;
            csum    <= rx_data;
            state   <= S_LO;
          end
          S_LO: if (accept) begin
            lo_byte <= rx_data;
            csum    <= csum ^ rx_data;
            state   <= S_HI;
          end
          S_HI: if (accept) begin
            imem_we    <= 1'b1;
            imem_addr  <= BASE_ADDR + IM_addr_width'(idx);
            imem_wdata <= {rx_data[IR_width-9:0], lo_byte};
            csum       <= csum ^ rx_data;
            idx        <= idx_inc[7:0];
            state      <= (idx_inc < {1'b0, n_words}) ? S_LO : S_CSUM;
          end
          S_CSUM: if (accept) begin
            state <= S_START;
            start <= 1'b1;
            done  <= 1'b1;
          end
          S_START: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader: cycle-exact sequences for the
// write/start timing, timeout and reset corners, plus a table of whole
// frames checked for their final status.
module tb_imem_stream_loader;

  localparam int TIMEOUT = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [11:0] imem_wdata;
  logic        proc_hold;
  logic        start;
  logic        done;
  logic        err;
  logic [2:0]  err_code;

  imem_stream_loader #(
    .IR_width      (12),
    .IM_addr_width (8),
    .BASE_ADDR     (8'h00),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT       (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .proc_hold  (proc_hold),
    .start      (start),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int wr_count = 0;
  int start_count = 0;
  logic [11:0] tb_mem [0:255];

  // Observe the memory port and start line as the processor side would.
  always @(posedge clk) begin
    if (imem_we) begin
      tb_mem[imem_addr] = imem_wdata;
      wr_count++;
    end
    if (start) start_count++;
  end

  typedef struct {
    string          name;
    logic [0:7][7:0] b;
    int             len;
    logic           exp_done;
    logic           exp_err;
    logic [2:0]     exp_code;
    int             exp_wr;
    int             exp_st;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int wr0;
    int st0;
    for (int i = 0; i < 256; i++) tb_mem[i] = 12'h000;

    // Frame table. Checksums are XOR of N and all payload bytes:
    // 02^34^01^BC^0A = 81, 01^12^03 = 10.
    vecs[0] = '{name: "good2",   b: {8'hA5, 8'h02, 8'h34, 8'h01, 8'hBC, 8'h0A, 8'h81, 8'h00},
                len: 7, exp_done: 1'b1, exp_err: 1'b0, exp_code: 3'd0, exp_wr: 2, exp_st: 1};
    vecs[1] = '{name: "badcsum", b: {8'hA5, 8'h02, 8'h34, 8'h01, 8'hBC, 8'h0A, 8'h84, 8'h00},
                len: 7, exp_done: 1'b0, exp_err: 1'b1, exp_code: 3'd3, exp_wr: 2, exp_st: 0};
    vecs[2] = '{name: "count0",  b: {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                len: 2, exp_done: 1'b0, exp_err: 1'b1, exp_code: 3'd1, exp_wr: 0, exp_st: 0};
    vecs[3] = '{name: "recover", b: {8'hA5, 8'h02, 8'h34, 8'h01, 8'hBC, 8'h0A, 8'h81, 8'h00},
                len: 7, exp_done: 1'b1, exp_err: 1'b0, exp_code: 3'd0, exp_wr: 2, exp_st: 1};
    vecs[4] = '{name: "format",  b: {8'hA5, 8'h01, 8'hFF, 8'h1F, 8'h00, 8'h00, 8'h00, 8'h00},
                len: 4, exp_done: 1'b0, exp_err: 1'b1, exp_code: 3'd2, exp_wr: 0, exp_st: 0};
    vecs[5] = '{name: "noise1",  b: {8'h12, 8'h34, 8'hA5, 8'h01, 8'h12, 8'h03, 8'h10, 8'h00},
                len: 7, exp_done: 1'b1, exp_err: 1'b0, exp_code: 3'd0, exp_wr: 1, exp_st: 1};

    // Reset state.
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", rx_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_hold", proc_hold, 0);
    check("rst_start", start, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_code", err_code, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("idle_ready", rx_ready, 1);

    // Cycle-exact good frame.
    send_byte(8'hA5);
    check("a_hold_after_sync", proc_hold, 1);
    send_byte(8'h02);
    send_byte(8'h34);
    check("a_no_we_on_lo", imem_we, 0);
    send_byte(8'h01);
    check("a_we0", imem_we, 1);
    check("a_addr0", imem_addr, 8'h00);
    check("a_data0", imem_wdata, 12'h134);
    send_byte(8'hBC);
    check("a_we_single", imem_we, 0);
    send_byte(8'h0A);
    check("a_we1", imem_we, 1);
    check("a_addr1", imem_addr, 8'h01);
    check("a_data1", imem_wdata, 12'hABC);
    check("a_hold_csum", proc_hold, 1);
    send_byte(8'h81);
    check("a_start", start, 1);
    check("a_done", done, 1);
    check("a_hold_start", proc_hold, 0);
    check("a_ready_start", rx_ready, 0);
    @(posedge clk);
    #1;
    check("a_start_pulse", start, 0);
    check("a_ready_back", rx_ready, 1);
    check("a_done_sticky", done, 1);
    check("a_mem0", tb_mem[0], 12'h134);
    check("a_mem1", tb_mem[1], 12'hABC);

    // Table of whole frames.
    for (int v = 0; v < 6; v++) begin
      wr0 = wr_count;
      st0 = start_count;
      for (int i = 0; i < vecs[v].len; i++) send_byte(vecs[v].b[i]);
      repeat (3) @(posedge clk);
      #1;
      check({vecs[v].name, "_done"}, done, vecs[v].exp_done);
      check({vecs[v].name, "_err"}, err, vecs[v].exp_err);
      check({vecs[v].name, "_code"}, err_code, vecs[v].exp_code);
      check({vecs[v].name, "_writes"}, wr_count - wr0, vecs[v].exp_wr);
      check({vecs[v].name, "_starts"}, start_count - st0, vecs[v].exp_st);
      check({vecs[v].name, "_hold"}, proc_hold, 0);
    end
    check("noise_mem0", tb_mem[0], 12'h312);

    // Timeout: error raised on the TIMEOUT-th idle cycle, not before.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h12);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    check("tmo_not_yet", err, 0);
    check("tmo_hold_before", proc_hold, 1);
    @(posedge clk);
    #1;
    check("tmo_err", err, 1);
    check("tmo_code", err_code, 3'd4);
    check("tmo_hold", proc_hold, 0);

    // Byte arriving on the expiry cycle wins.
    st0 = start_count;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h12);
    repeat (TIMEOUT - 1) @(posedge clk);
    send_byte(8'h03);
    check("exp_byte_err", err, 0);
    check("exp_byte_hold", proc_hold, 1);
    send_byte(8'h10);
    check("exp_byte_start", start, 1);
    check("exp_byte_done", done, 1);
    @(posedge clk);
    #1;
    check("exp_byte_starts", start_count - st0, 1);

    // Reset during the HI byte of a 3-word frame.
    wr0 = wr_count;
    st0 = start_count;
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h01);
    send_byte(8'h22);
    send_byte(8'h02);
    send_byte(8'h33);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h03;
    reset    = 1'b0;
    @(posedge clk);
    #1;
    check("mr_ready", rx_ready, 0);
    check("mr_we", imem_we, 0);
    check("mr_addr", imem_addr, 0);
    check("mr_wdata", imem_wdata, 0);
    check("mr_hold", proc_hold, 0);
    check("mr_start", start, 0);
    check("mr_done", done, 0);
    check("mr_err", err, 0);
    check("mr_code", err_code, 0);
    rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    repeat (2) @(posedge clk);
    #1;
    check("mr_writes", wr_count - wr0, 2);
    check("mr_starts", start_count - st0, 0);
    check("mr_mem0", tb_mem[0], 12'h111);
    check("mr_mem1", tb_mem[1], 12'h222);
    check("mr_noise_hold", proc_hold, 0);
    check("mr_noise_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
